// File: rtl/mprj_mailbox.sv
// mprj_mailbox: two-direction message mailbox between the Caravel management
// SoC (32-bit classic Wishbone) and the microwatt core (64-bit pipelined
// Wishbone). S2M carries SoC-to-microwatt words, M2S carries
// microwatt-to-SoC words; a level interrupt flags pending M2S data.

// Single FIFO channel. Full/empty reflect the state at the start of the
// cycle; a push while full is dropped and latches the sticky overflow flag.
module mprj_mailbox_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [31:0]                wdata,
   output logic [31:0]                head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          ovf_reg;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign ovf     = ovf_reg;
   assign head    = mem[rd_ptr_reg];

   // Flush dominates: a push or pop coinciding with it has no effect on state.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (push & full) begin
            ovf_reg <= 1'b1;
         end
      end
   end

endmodule

// Top level: bus decode for both sides, status word, control and interrupt.
module mprj_mailbox #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic        ext_clk,
   input  logic        ext_rst,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        wb_la_cyc,
   input  logic        wb_la_stb,
   input  logic        wb_la_we,
   input  logic [31:0] wb_la_adr,
   input  logic [63:0] wb_la_dat_o,
   input  logic [7:0]  wb_la_sel,
   output logic [63:0] wb_la_dat_i,
   output logic        wb_la_ack,
   output logic        wb_la_stall,
   output logic        mbox_irq_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int S2M = 0;
   localparam int M2S = 1;

   logic              wbs_req;
   logic              wbs_hit;
   logic [1:0]        wbs_off;
   logic              la_req;
   logic              ctrl_wr;
   logic              fifo_flush;
   logic              irq_en_reg;
   logic [31:0]       status_word;
   logic [31:0]       wbs_rdata_next;
   logic [31:0]       la_rdata_next;

   logic [1:0]        fifo_push;
   logic [1:0]        fifo_pop;
   logic [1:0]        fifo_full;
   logic [1:0]        fifo_empty;
   logic [1:0]        fifo_ovf;
   logic [1:0][31:0]  fifo_wdata;
   logic [1:0][31:0]  fifo_head;
   logic [1:0][AW:0]  fifo_count;

   // Byte selects and unused address/data bits: every access is a full word.
   logic unused_ok;
   assign unused_ok = &{1'b0, wbs_sel_i, wb_la_sel, wb_la_adr[31:1],
                        wb_la_dat_o[63:32], wbs_adr_i[1:0]};

   // A classic request is masked while its own ack is on the bus so a held
   // strobe is not taken twice.
   assign wbs_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign wbs_hit  = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign wbs_off  = wbs_adr_i[3:2];
   assign la_req   = wb_la_cyc & wb_la_stb;

   assign ctrl_wr    = wbs_req & wbs_hit & wbs_we_i & (wbs_off == 2'd2);
   assign fifo_flush = ctrl_wr & wbs_dat_i[1];

   assign fifo_push[S2M]  = wbs_req & wbs_hit & wbs_we_i & (wbs_off == 2'd0);
   assign fifo_pop[S2M]   = la_req & ~wb_la_we & ~wb_la_adr[0];
   assign fifo_wdata[S2M] = wbs_dat_i;

   assign fifo_push[M2S]  = la_req & wb_la_we & ~wb_la_adr[0];
   assign fifo_pop[M2S]   = wbs_req & wbs_hit & ~wbs_we_i & (wbs_off == 2'd0);
   assign fifo_wdata[M2S] = wb_la_dat_o[31:0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         mprj_mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (ext_clk),
            .rst_n (ext_rst),
            .flush (fifo_flush),
            .push  (fifo_push[gi]),
            .pop   (fifo_pop[gi]),
            .wdata (fifo_wdata[gi]),
            .head  (fifo_head[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty[gi]),
            .count (fifo_count[gi]),
            .ovf   (fifo_ovf[gi])
         );
      end
   endgenerate

   assign status_word = {8'h00,
                         8'(fifo_count[M2S]),
                         8'(fifo_count[S2M]),
                         2'b00,
                         fifo_ovf[M2S], fifo_ovf[S2M],
                         fifo_empty[M2S], fifo_full[M2S],
                         fifo_empty[S2M], fifo_full[S2M]};

   // Caravel read mux; misses and the spare slot read as zero.
   always_comb begin
      wbs_rdata_next = 32'h0;
      if (wbs_hit) begin
         case (wbs_off)
            2'd0:    wbs_rdata_next = fifo_empty[M2S] ? 32'h0 : fifo_head[M2S];
            2'd1:    wbs_rdata_next = status_word;
            2'd2:    wbs_rdata_next = {31'h0, irq_en_reg};
            default: wbs_rdata_next = 32'h0;
         endcase
      end
   end

   // Microwatt read mux; bit 0 of the word address picks DATA or STATUS.
   always_comb begin
      la_rdata_next = 32'h0;
      if (wb_la_adr[0]) begin
         la_rdata_next = status_word;
      end else if (!fifo_empty[S2M]) begin
         la_rdata_next = fifo_head[S2M];
      end
   end

   // Caravel response: single-cycle ack one cycle after the request.
   always_ff @(posedge ext_clk or negedge ext_rst) begin
      if (!ext_rst) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= 32'h0;
      end else begin
         wbs_ack_o <= wbs_req;
         wbs_dat_o <= (wbs_req & ~wbs_we_i) ? wbs_rdata_next : 32'h0;
      end
   end

   // Microwatt response: one ack per accepted request, no stall.
   always_ff @(posedge ext_clk or negedge ext_rst) begin
      if (!ext_rst) begin
         wb_la_ack   <= 1'b0;
         wb_la_dat_i <= 64'h0;
      end else begin
         wb_la_ack   <= la_req;
         wb_la_dat_i <= (la_req & ~wb_la_we) ? {32'h0, la_rdata_next} : 64'h0;
      end
   end

   assign wb_la_stall = 1'b0;

   // Interrupt enable, written through CTRL bit 0.
   always_ff @(posedge ext_clk or negedge ext_rst) begin
      if (!ext_rst) begin
         irq_en_reg <= 1'b0;
      end else if (ctrl_wr) begin
         irq_en_reg <= wbs_dat_i[0];
      end
   end

   // Registered level interrupt: pending M2S data while enabled.
   always_ff @(posedge ext_clk or negedge ext_rst) begin
      if (!ext_rst) begin
         mbox_irq_o <= 1'b0;
      end else begin
         mbox_irq_o <= irq_en_reg & ~fifo_empty[M2S];
      end
   end

endmodule

// File: tb/tb_mprj_mailbox.sv
// Testbench for mprj_mailbox: directed scenarios followed by random traffic
// on both buses, checked by a queue-based reference model and scoreboard.
module tb_mprj_mailbox;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic        ext_clk;
   logic        ext_rst;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        wb_la_cyc, wb_la_stb, wb_la_we;
   logic [31:0] wb_la_adr;
   logic [63:0] wb_la_dat_o;
   logic [7:0]  wb_la_sel;
   logic [63:0] wb_la_dat_i;
   logic        wb_la_ack, wb_la_stall, mbox_irq_o;

   mprj_mailbox #(.DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
      .ext_clk     (ext_clk),
      .ext_rst     (ext_rst),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_sel_i   (wbs_sel_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .wb_la_cyc   (wb_la_cyc),
      .wb_la_stb   (wb_la_stb),
      .wb_la_we    (wb_la_we),
      .wb_la_adr   (wb_la_adr),
      .wb_la_dat_o (wb_la_dat_o),
      .wb_la_sel   (wb_la_sel),
      .wb_la_dat_i (wb_la_dat_i),
      .wb_la_ack   (wb_la_ack),
      .wb_la_stall (wb_la_stall),
      .mbox_irq_o  (mbox_irq_o)
   );

   initial ext_clk = 1'b0;
   always #5 ext_clk = ~ext_clk;

   typedef struct {
      int          stamp;
      bit          is_read;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      int stamp;
      bit v;
   } irq_exp_t;

   int       checks   = 0;
   int       failures = 0;
   int       neg_cnt  = 0;
   exp_t     wbs_q[$];
   exp_t     la_q[$];
   irq_exp_t irq_q[$];

   // Reference model: plain queues of the words each FIFO should hold.
   logic [31:0] m_s2m[$];
   logic [31:0] m_m2s[$];
   bit          m_s2m_ovf, m_m2s_ovf, m_irq_en;
   bit          c_prev;

   function automatic logic [31:0] m_status();
      return {8'h00, 8'(m_m2s.size()), 8'(m_s2m.size()), 2'b00,
              m_m2s_ovf, m_s2m_ovf,
              (m_m2s.size() == 0), (m_m2s.size() == DEPTH),
              (m_s2m.size() == 0), (m_s2m.size() == DEPTH)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, neg_cnt, act, exp);
      end
   endtask

   // Monitor: on every falling edge compare whatever the DUT presents against
   // the oldest expectation for that bus.
   always @(negedge ext_clk) begin
      exp_t e;
      neg_cnt++;
      if (!ext_rst) begin
         check("rst_wbs_ack", {63'h0, wbs_ack_o}, 64'h0);
         check("rst_la_ack", {63'h0, wb_la_ack}, 64'h0);
         check("rst_irq", {63'h0, mbox_irq_o}, 64'h0);
         check("rst_wbs_dat", {32'h0, wbs_dat_o}, 64'h0);
         check("rst_la_dat", wb_la_dat_i, 64'h0);
         check("rst_stall", {63'h0, wb_la_stall}, 64'h0);
      end else begin
         if (wbs_ack_o) begin
            if (wbs_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL wbs_unexpected_ack cycle=%0d actual=1 required=0", neg_cnt);
            end else begin
               e = wbs_q.pop_front();
               check("wbs_ack_time", 64'(e.stamp), 64'(neg_cnt));
               if (e.is_read) check("wbs_rdata", {32'h0, wbs_dat_o}, e.data);
               $display("wbs ack cycle=%0d rd=%0d dat=%h", neg_cnt, e.is_read, wbs_dat_o);
            end
         end else if (wbs_q.size() > 0 && wbs_q[0].stamp <= neg_cnt) begin
            void'(wbs_q.pop_front());
            checks++; failures++;
            $display("FAIL wbs_missing_ack cycle=%0d actual=0 required=1", neg_cnt);
         end
         if (wb_la_ack) begin
            if (la_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL la_unexpected_ack cycle=%0d actual=1 required=0", neg_cnt);
            end else begin
               e = la_q.pop_front();
               check("la_ack_time", 64'(e.stamp), 64'(neg_cnt));
               if (e.is_read) check("la_rdata", wb_la_dat_i, e.data);
               $display("la  ack cycle=%0d rd=%0d dat=%h", neg_cnt, e.is_read, wb_la_dat_i);
            end
         end else if (la_q.size() > 0 && la_q[0].stamp <= neg_cnt) begin
            void'(la_q.pop_front());
            checks++; failures++;
            $display("FAIL la_missing_ack cycle=%0d actual=0 required=1", neg_cnt);
         end
         if (irq_q.size() > 0 && irq_q[0].stamp == neg_cnt) begin
            irq_exp_t ie;
            ie = irq_q.pop_front();
            check("irq", {63'h0, mbox_irq_o}, {63'h0, ie.v});
         end
      end
   end

   // One clock of stimulus on both buses; c_op/l_op: 0 idle, 1 read, 2 write.
   task automatic do_cycle(input int c_op, input logic [31:0] c_adr, input logic [31:0] c_dat,
                           input int l_op, input logic l_a0, input logic [31:0] l_dat);
      exp_t        e;
      irq_exp_t    ie;
      logic [31:0] c_rd, l_rd;
      bit          c_hit, flush, s_full, s_empty, m_full, m_empty;
      logic [1:0]  c_off;
      if (c_prev) c_op = 0;
      wbs_cyc_i   = (c_op != 0);
      wbs_stb_i   = (c_op != 0);
      wbs_we_i    = (c_op == 2);
      wbs_adr_i   = c_adr;
      wbs_dat_i   = c_dat;
      wbs_sel_i   = 4'($urandom);
      wb_la_cyc   = (l_op != 0);
      wb_la_stb   = (l_op != 0);
      wb_la_we    = (l_op == 2);
      wb_la_adr   = {31'($urandom), l_a0};
      wb_la_dat_o = {32'($urandom), l_dat};
      wb_la_sel   = 8'($urandom);

      ie.stamp = neg_cnt + 1;
      ie.v     = m_irq_en && (m_m2s.size() > 0);
      irq_q.push_back(ie);

      c_hit = (c_adr[31:4] == BASE[31:4]);
      c_off = c_adr[3:2];
      c_rd  = 32'h0;
      if (c_hit) begin
         case (c_off)
            2'd0:    if (m_m2s.size() > 0) c_rd = m_m2s[0];
            2'd1:    c_rd = m_status();
            2'd2:    c_rd = {31'h0, m_irq_en};
            default: c_rd = 32'h0;
         endcase
      end
      if (l_a0) l_rd = m_status();
      else      l_rd = (m_s2m.size() > 0) ? m_s2m[0] : 32'h0;

      if (c_op != 0) begin
         e.stamp = neg_cnt + 1; e.is_read = (c_op == 1); e.data = {32'h0, c_rd};
         wbs_q.push_back(e);
      end
      if (l_op != 0) begin
         e.stamp = neg_cnt + 1; e.is_read = (l_op == 1); e.data = {32'h0, l_rd};
         la_q.push_back(e);
      end

      flush   = (c_op == 2) && c_hit && (c_off == 2'd2) && c_dat[1];
      s_full  = (m_s2m.size() == DEPTH);
      s_empty = (m_s2m.size() == 0);
      m_full  = (m_m2s.size() == DEPTH);
      m_empty = (m_m2s.size() == 0);
      if (flush) begin
         m_s2m.delete(); m_m2s.delete();
         m_s2m_ovf = 0; m_m2s_ovf = 0;
      end else begin
         if (l_op == 1 && !l_a0 && !s_empty) void'(m_s2m.pop_front());
         if (c_op == 2 && c_hit && c_off == 2'd0) begin
            if (s_full) m_s2m_ovf = 1;
            else        m_s2m.push_back(c_dat);
         end
         if (c_op == 1 && c_hit && c_off == 2'd0 && !m_empty) void'(m_m2s.pop_front());
         if (l_op == 2 && !l_a0) begin
            if (m_full) m_m2s_ovf = 1;
            else        m_m2s.push_back(l_dat);
         end
      end
      if ((c_op == 2) && c_hit && (c_off == 2'd2)) m_irq_en = c_dat[0];
      c_prev = (c_op != 0);
      if (c_op != 0 || l_op != 0)
         $display("req cycle=%0d c_op=%0d adr=%h dat=%h l_op=%0d a0=%0d dat=%h",
                  neg_cnt, c_op, c_adr, c_dat, l_op, l_a0, l_dat);
      @(negedge ext_clk); #1;
   endtask

   task automatic idle();
      do_cycle(0, 32'h0, 32'h0, 0, 1'b0, 32'h0);
   endtask
   task automatic cw(input logic [31:0] adr, input logic [31:0] dat);
      do_cycle(2, adr, dat, 0, 1'b0, 32'h0); idle();
   endtask
   task automatic cr(input logic [31:0] adr);
      do_cycle(1, adr, 32'h0, 0, 1'b0, 32'h0); idle();
   endtask

   task automatic model_reset();
      m_s2m.delete(); m_m2s.delete();
      m_s2m_ovf = 0; m_m2s_ovf = 0; m_irq_en = 0; c_prev = 0;
      wbs_q.delete(); la_q.delete(); irq_q.delete();
   endtask

   initial begin
      ext_rst = 1'b0;
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
      wbs_adr_i = 0; wbs_dat_i = 0;
      wb_la_cyc = 0; wb_la_stb = 0; wb_la_we = 0; wb_la_adr = 0;
      wb_la_dat_o = 0; wb_la_sel = 0;
      model_reset();
      repeat (3) @(negedge ext_clk);
      #1 ext_rst = 1'b1;

      // Reset state
      cr(BASE + 32'h4);
      do_cycle(0, 32'h0, 32'h0, 1, 1'b1, 32'h0); idle();

      // SoC -> microwatt single word
      cw(BASE, 32'hDEAD_BEEF);
      do_cycle(0, 32'h0, 32'h0, 1, 1'b0, 32'h0);
      do_cycle(0, 32'h0, 32'h0, 1, 1'b1, 32'h0); idle();

      // Interrupt and M2S overflow with back-to-back microwatt writes
      cw(BASE + 32'h8, 32'h1);
      for (int i = 0; i < 5; i++) do_cycle(0, 32'h0, 32'h0, 2, 1'b0, 32'h1000 + i);
      idle(); idle();
      cr(BASE + 32'h4);
      for (int i = 0; i < 5; i++) cr(BASE);
      cr(BASE + 32'h8);

      // Same-cycle SoC pop and microwatt push at count 2
      cw(BASE + 32'h8, 32'h3);
      do_cycle(0, 32'h0, 32'h0, 2, 1'b0, 32'hA1);
      do_cycle(0, 32'h0, 32'h0, 2, 1'b0, 32'hA2);
      do_cycle(1, BASE, 32'h0, 2, 1'b0, 32'hA3); idle();
      cr(BASE + 32'h4);

      // Empty read, address miss, spare slot
      cw(BASE + 32'h8, 32'h2);
      cr(BASE);
      cr(BASE + 32'h100);
      cw(BASE + 32'h100, 32'h55);
      cw(BASE + 32'hC, 32'h77);
      cr(BASE + 32'hC);
      cr(BASE + 32'h4);

      // S2M overflow from the SoC side, then flush racing a push
      for (int i = 0; i < 5; i++) cw(BASE, 32'h2000 + i);
      cr(BASE + 32'h4);
      do_cycle(2, BASE + 32'h8, 32'h2, 2, 1'b0, 32'hBB); idle();
      cr(BASE + 32'h4);

      // Reset while a SoC ack is owed and S2M holds 3 entries
      for (int i = 0; i < 3; i++) cw(BASE, 32'h3000 + i);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h4;
      #2 ext_rst = 1'b0;
      model_reset();
      @(negedge ext_clk); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0;
      repeat (2) @(negedge ext_clk);
      #1 ext_rst = 1'b1;
      cr(BASE + 32'h4);

      // Random traffic on both buses
      for (int n = 0; n < 600; n++) begin
         int          c_op, l_op;
         logic [31:0] adr, dat;
         logic        a0;
         c_op = $urandom_range(0, 2);
         case ($urandom_range(0, 7))
            0, 1, 2: adr = BASE;
            3, 4:    adr = BASE + 32'h4;
            5:       adr = BASE + 32'h8;
            6:       adr = BASE + 32'hC;
            default: adr = BASE + 32'h100;
         endcase
         dat = $urandom;
         if (adr == BASE + 32'h8) dat[1] = ($urandom_range(0, 7) == 0);
         l_op = $urandom_range(0, 2);
         a0   = ($urandom_range(0, 3) == 0);
         do_cycle(c_op, adr, dat, l_op, a0, 32'($urandom));
      end
      repeat (4) idle();

      checks++;
      if (wbs_q.size() != 0 || la_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d/%0d required=0/0", wbs_q.size(), la_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mprj_mailbox.md
Name: mprj_mailbox

Overview:
- Two-direction message mailbox between the Caravel management SoC and the microwatt core inside the user project.
- Caravel side: 32-bit classic Wishbone slave on the wbs_* bus.
- Microwatt side: 64-bit pipelined Wishbone slave that terminates the core's wb_la_* master port. Port names match the core's, so the two connect one-to-one.
- Two FIFOs: S2M carries SoC-to-microwatt messages; M2S carries microwatt-to-SoC messages. A level interrupt tells the SoC that M2S holds data.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, minimum 2.
- BASE_ADR, 32'h3000_0000, Caravel-side base address; decode compares wbs_adr_i[31:4] with BASE_ADR[31:4].

Ports:
- ext_clk  in  1  single clock for the whole block; Caravel bus and microwatt share it.
- ext_rst  in  1  asynchronous, active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Caravel classic Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte selects; ignored, every write is a full word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- wb_la_cyc, wb_la_stb, wb_la_we  in  1 each  microwatt request signals.
- wb_la_adr  in  32  word address; bit 0 selects the register.
- wb_la_dat_o  in  64  microwatt write data.
- wb_la_sel  in  8  byte selects; ignored.
- wb_la_dat_i  out  64  read data to microwatt.
- wb_la_ack  out  1  acknowledge to microwatt.
- wb_la_stall  out  1  stall; tied 0.
- mbox_irq_o  out  1  level interrupt to the SoC.

Behaviour:
Reset (ext_rst low, asynchronous):
- Both FIFOs empty; all pointers and counts 0.
- irq_en = 0; overflow flags = 0.
- wbs_ack_o, wb_la_ack, mbox_irq_o = 0; wbs_dat_o and wb_la_dat_i = 0.
- A transaction in flight is abandoned; its ack is never issued.

Caravel register map (byte offsets):
- 0x0 DATA. Write pushes wbs_dat_i into S2M. Read pops M2S and returns the head entry. Reading when M2S is empty returns 0 and does not pop.
- 0x4 STATUS (read-only):
  - [0] s2m_full, [1] s2m_empty, [2] m2s_full, [3] m2s_empty
  - [4] s2m_ovf, [5] m2s_ovf
  - [15:8] s2m_count, [23:16] m2s_count, zero-extended
  - other bits 0
- 0x8 CTRL:
  - [0] irq_en, read/write.
  - [1] flush, write-only: writing 1 empties both FIFOs and clears both ovf flags in that cycle; reads as 0.
- 0xC: reads 0, writes ignored.

Caravel handshake:
- A request is wbs_cyc_i & wbs_stb_i & ~wbs_ack_o.
- wbs_ack_o is registered: it is high for exactly one cycle, in the cycle after the request. Read data is valid in that same cycle.
- Side effects (push, pop, CTRL update) happen on the request edge.
- Addresses that miss BASE_ADR are still acked; reads return 0 and writes are ignored, so the bus never hangs.

Microwatt handshake:
- Pipelined, no stall; a request is accepted every cycle that wb_la_cyc & wb_la_stb is high.
- wb_la_ack is high exactly 1 cycle after each accepted request. Back-to-back requests give back-to-back acks.
- wb_la_adr[0]=0, DATA:
  - Write pushes wb_la_dat_o[31:0] into M2S.
  - Read pops S2M and returns the entry in [31:0] with [63:32]=0. Reading when S2M is empty returns 0 and does not pop.
- wb_la_adr[0]=1, STATUS: same layout as the Caravel STATUS register, in [31:0]; writes ignored.
- Dropping wb_la_cyc does not cancel acks already owed.

FIFO rules:
- Full and empty are evaluated on the state at the start of the cycle.
- A push while full is dropped and sets the sticky ovf flag, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle on a non-full, non-empty FIFO both take effect; count is unchanged.
- A push to an empty FIFO is visible to a pop from the next cycle on.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Flush and push in the same cycle: flush wins and the push is discarded.

Interrupt:
- mbox_irq_o = irq_en & ~m2s_empty, registered, so it trails the state change by 1 cycle.

Test Plan:
1. Reset: hold ext_rst low, then release -> STATUS reads 0x0000_000A (both FIFOs empty); mbox_irq_o=0; no acks issued.
2. Caravel writes 0x3000_0000 <= 0xDEADBEEF; then microwatt reads adr 0 -> wb_la_ack 1 cycle after the request, wb_la_dat_i=0x0000_0000_DEADBEEF; S2M empty afterwards.
3. Set irq_en=1; microwatt issues 5 back-to-back writes with DEPTH=4 -> 5 consecutive acks; m2s_count=4, m2s_ovf=1; mbox_irq_o rises 1 cycle after the first push; SoC then pops data in the original order.
4. Same-cycle Caravel pop of M2S and microwatt push into M2S with count=2 -> count stays 2; popped value is the oldest entry.
5. Caravel reads DATA with M2S empty -> returns 0, ack 1 cycle later, count stays 0; access to 0x3000_0100 -> acked, reads 0.
6. Pull ext_rst low while a Caravel ack is pending and S2M holds 3 entries -> no ack issued; after release, STATUS=0x0000_000A.
